// File: rtl/philo_pkg.sv
// Shared encodings for the dining-philosophers monitor: philosopher states,
// event codes and the legal state-transition table.
package philo_pkg;

  typedef enum logic [1:0] {
    ST_THINK  = 2'd0,
    ST_PASS   = 2'd1,
    ST_EAT    = 2'd2,
    ST_HUNGRY = 2'd3
  } phil_st_e;

  typedef enum logic [1:0] {
    EV_EAT_START = 2'd0,
    EV_STARVE    = 2'd1,
    EV_SAFETY    = 2'd2,
    EV_ILLEGAL   = 2'd3
  } ev_code_e;

  function automatic logic legal_trans(input logic [1:0] prev, input logic [1:0] cur);
    logic ok;
    case (prev)
      ST_THINK:  ok = (cur != ST_EAT);
      ST_PASS:   ok = (cur == ST_PASS)   || (cur == ST_THINK);
      ST_EAT:    ok = (cur == ST_EAT)    || (cur == ST_THINK);
      ST_HUNGRY: ok = (cur == ST_HUNGRY) || (cur == ST_EAT);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/philo_if.sv
// Valid/ready event stream carrying the philosopher index and event code.
interface philo_if #(
  parameter int N = 8
);
  localparam int IDX_W = $clog2(N);

  logic             ev_valid;
  logic             ev_ready;
  logic [IDX_W-1:0] ev_idx;
  logic [1:0]       ev_code;

  modport master (output ev_valid, output ev_idx, output ev_code, input ev_ready);
  modport slave  (input ev_valid, input ev_idx, input ev_code, output ev_ready);
endinterface

// File: rtl/philo_watch.sv
// Per-philosopher watcher: previous-state register, hungry wait counter and
// the four raw detections (safety, illegal transition, starvation, eat start).
module philo_watch
  import philo_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int STARVE_LIMIT = 100
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             prev_valid,
  input  logic [1:0]       st_cur,
  input  logic [1:0]       st_nb,
  output logic             det_safety,
  output logic             det_illegal,
  output logic             det_starve,
  output logic             det_eat,
  output logic [CNT_W-1:0] cnt_next
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  logic [1:0]       prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic             active_s;

  assign active_s = enable & ~clear;

  // Previous state is sampled every cycle regardless of enable or clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_r <= 2'd0;
    end else begin
      prev_r <= st_cur;
    end
  end

  // Wait counter next value: holds while disabled, saturates while hungry.
  always_comb begin
    cnt_next = cnt_r;
    if (clear) begin
      cnt_next = {CNT_W{1'b0}};
    end else if (!enable) begin
      cnt_next = cnt_r;
    end else if (st_cur == ST_HUNGRY) begin
      cnt_next = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 1'b1;
    end else begin
      cnt_next = {CNT_W{1'b0}};
    end
  end

  // Wait counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_next;
    end
  end

  // Starvation fires only on the increment that lands exactly on the limit.
  assign det_safety  = active_s && (st_cur == ST_EAT) && (st_nb == ST_EAT);
  assign det_illegal = active_s && prev_valid && !legal_trans(prev_r, st_cur);
  assign det_eat     = active_s && prev_valid && (prev_r == ST_HUNGRY) && (st_cur == ST_EAT);
  assign det_starve  = active_s && (st_cur == ST_HUNGRY) && (cnt_r == LIMIT_M1);

endmodule

// File: rtl/philo_monitor.sv
// Ring monitor top: one watcher per philosopher, priority event select,
// event queue, lost-event counter and the sticky status outputs.
module philo_monitor
  import philo_pkg::*;
#(
  parameter int N            = 8,
  parameter int CNT_W        = 8,
  parameter int STARVE_LIMIT = 100,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2*N-1:0]   st,
  input  logic             enable,
  input  logic             clear,
  philo_if.master          ev,
  output logic             safety_err,
  output logic [N-1:0]     starve,
  output logic [CNT_W-1:0] ev_drop,
  output logic [CNT_W-1:0] hungry_max
);

  localparam int IDX_W  = $clog2(N);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam int DET_W  = $clog2(4 * N + 1);
  localparam int SUM_W  = CNT_W + DET_W + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_FW-1:0] DEPTH_C = CNT_FW'(FIFO_DEPTH);

  logic [N-1:0]       det_safety_s, det_illegal_s, det_starve_s, det_eat_s;
  logic [CNT_W-1:0]   cnt_next_s [N];
  logic               prev_valid_r;
  logic               safety_err_r;
  logic [N-1:0]       starve_r;
  logic [CNT_W-1:0]   ev_drop_r, hungry_max_r, drop_next_s, hungry_next_s;
  logic               sel_valid_s;
  logic [IDX_W-1:0]   sel_idx_s;
  logic [1:0]         sel_code_s;
  logic [DET_W-1:0]   det_cnt_s;
  logic [SUM_W-1:0]   drop_sum_s;
  logic               pop_s, push_s, lost_s, full_s;
  logic [IDX_W-1:0]   mem_idx_r  [FIFO_DEPTH];
  logic [1:0]         mem_code_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNT_FW-1:0]  count_r;

  for (genvar gi = 0; gi < N; gi++) begin : g_watch
    philo_watch #(
      .CNT_W        (CNT_W),
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_watch (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (enable),
      .clear       (clear),
      .prev_valid  (prev_valid_r),
      .st_cur      (st[2*gi +: 2]),
      .st_nb       (st[2*((gi+1)%N) +: 2]),
      .det_safety  (det_safety_s[gi]),
      .det_illegal (det_illegal_s[gi]),
      .det_starve  (det_starve_s[gi]),
      .det_eat     (det_eat_s[gi]),
      .cnt_next    (cnt_next_s[gi])
    );
  end

  function automatic logic [IDX_W-1:0] low_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      r = v[i] ? IDX_W'(i) : r;
    end
    return r;
  endfunction

  // Priority select: category first, then lowest index.
  always_comb begin
    sel_valid_s = |{det_safety_s, det_illegal_s, det_starve_s, det_eat_s};
    if (|det_safety_s) begin
      sel_code_s = EV_SAFETY;
      sel_idx_s  = low_idx(det_safety_s);
    end else if (|det_illegal_s) begin
      sel_code_s = EV_ILLEGAL;
      sel_idx_s  = low_idx(det_illegal_s);
    end else if (|det_starve_s) begin
      sel_code_s = EV_STARVE;
      sel_idx_s  = low_idx(det_starve_s);
    end else begin
      sel_code_s = EV_EAT_START;
      sel_idx_s  = low_idx(det_eat_s);
    end
  end

  // Total detections this cycle; all but the selected one are lost.
  always_comb begin
    det_cnt_s = {DET_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      det_cnt_s = det_cnt_s + DET_W'(det_safety_s[i]) + DET_W'(det_illegal_s[i])
                + DET_W'(det_starve_s[i]) + DET_W'(det_eat_s[i]);
    end
  end

  assign pop_s  = ev.ev_valid & ev.ev_ready;
  assign full_s = (count_r == DEPTH_C);
  assign push_s = sel_valid_s & (~full_s | pop_s);
  assign lost_s = sel_valid_s & ~push_s;

  // Lost-event accumulation with saturation.
  always_comb begin
    drop_sum_s = SUM_W'(ev_drop_r);
    if (sel_valid_s) begin
      drop_sum_s = SUM_W'(ev_drop_r) + SUM_W'(det_cnt_s) + SUM_W'(lost_s) - SUM_W'(1'b1);
    end else begin
      drop_sum_s = SUM_W'(ev_drop_r);
    end
  end

  assign drop_next_s = (drop_sum_s > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum_s[CNT_W-1:0];

  // Running maximum over the freshly updated wait counters.
  always_comb begin
    hungry_next_s = hungry_max_r;
    for (int i = 0; i < N; i++) begin
      hungry_next_s = (cnt_next_s[i] > hungry_next_s) ? cnt_next_s[i] : hungry_next_s;
    end
  end

  // Event queue storage and pointers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_idx_r[i]  <= {IDX_W{1'b0}};
        mem_code_r[i] <= 2'd0;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_FW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_FW{1'b0}};
    end else begin
      if (push_s) begin
        mem_idx_r[wr_ptr_r]  <= sel_idx_s;
        mem_code_r[wr_ptr_r] <= sel_code_s;
        wr_ptr_r             <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flags, counters and the prev-valid qualifier.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_valid_r <= 1'b0;
      safety_err_r <= 1'b0;
      starve_r     <= {N{1'b0}};
      ev_drop_r    <= {CNT_W{1'b0}};
      hungry_max_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      prev_valid_r <= 1'b0;
      safety_err_r <= 1'b0;
      starve_r     <= {N{1'b0}};
      ev_drop_r    <= {CNT_W{1'b0}};
      hungry_max_r <= {CNT_W{1'b0}};
    end else begin
      prev_valid_r <= 1'b1;
      safety_err_r <= safety_err_r | (|det_safety_s);
      starve_r     <= starve_r | det_starve_s;
      ev_drop_r    <= drop_next_s;
      hungry_max_r <= hungry_next_s;
    end
  end

  assign ev.ev_valid = (count_r != {CNT_FW{1'b0}});
  assign ev.ev_idx   = mem_idx_r[rd_ptr_r];
  assign ev.ev_code  = mem_code_r[rd_ptr_r];
  assign safety_err  = safety_err_r;
  assign starve      = starve_r;
  assign ev_drop     = ev_drop_r;
  assign hungry_max  = hungry_max_r;

endmodule

// File: tb/tb_philo_monitor.sv
// Directed bench for philo_monitor: a per-cycle vector table plus sequences
// for starvation, queue overflow/drain and mid-run reset.
module tb_philo_monitor;

  localparam int N  = 8;
  localparam int NV = 21;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b0;
  logic        clear   = 1'b0;
  logic [15:0] st      = 16'h0000;
  logic        safety_err;
  logic [7:0]  starve, ev_drop, hungry_max;

  int checks   = 0;
  int failures = 0;

  philo_if #(.N(N)) ev_if ();

  philo_monitor #(
    .N            (N),
    .CNT_W        (8),
    .STARVE_LIMIT (100),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .st         (st),
    .enable     (enable),
    .clear      (clear),
    .ev         (ev_if),
    .safety_err (safety_err),
    .starve     (starve),
    .ev_drop    (ev_drop),
    .hungry_max (hungry_max)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] st;
    logic        en;
    logic        clr;
    logic        rdy;
    logic        exp_valid;
    logic [2:0]  exp_idx;
    logic [1:0]  exp_code;
    logic        exp_safety;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Walk philosopher p through THINK -> HUNGRY -> EAT -> THINK.
  task automatic eat_cycle(input int p);
    st = 16'h0000; st[2*p +: 2] = 2'b11; step();
    st[2*p +: 2] = 2'b10; step();
    st = 16'h0000; step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  initial begin
    int          hits;
    int          hit_k;
    logic [2:0]  hit_idx;
    logic [1:0]  hit_code;
    logic [2:0]  exp_q [4];

    //                st        en    clr   rdy   vld   idx   code  saf   drop
    tbl[0]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};
    tbl[1]  = '{16'h0F00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};
    tbl[2]  = '{16'h0A00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 2'd2, 1'b1, 8'd2};
    tbl[3]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 8'd2};
    tbl[4]  = '{16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};
    tbl[5]  = '{16'h3000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};
    tbl[6]  = '{16'h2008, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 2'd3, 1'b0, 8'd1};
    tbl[7]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd1};
    tbl[8]  = '{16'hC003, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd1};
    tbl[9]  = '{16'h8002, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};
    tbl[10] = '{16'hC003, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};
    tbl[11] = '{16'hC003, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};
    tbl[12] = '{16'h8002, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 2'd2, 1'b1, 8'd2};
    tbl[13] = '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 8'd2};
    tbl[14] = '{16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};
    tbl[15] = '{16'h0080, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};
    tbl[16] = '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};
    tbl[17] = '{16'h0010, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};
    tbl[18] = '{16'h0030, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 2'd3, 1'b0, 8'd0};
    tbl[19] = '{16'h0020, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 2'd0, 1'b0, 8'd0};
    tbl[20] = '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};

    ev_if.ev_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", ev_if.ev_valid, 1'b0);
    check("rst_idx", ev_if.ev_idx, 3'd0);
    check("rst_code", ev_if.ev_code, 2'd0);
    check("rst_safety", safety_err, 1'b0);
    check("rst_starve", starve, 8'h00);
    check("rst_drop", ev_drop, 8'd0);
    check("rst_hmax", hungry_max, 8'd0);
    reset_n = 1'b1;
    enable  = 1'b1;

    for (int k = 0; k < NV; k++) begin
      st             = tbl[k].st;
      enable         = tbl[k].en;
      clear          = tbl[k].clr;
      ev_if.ev_ready = tbl[k].rdy;
      step();
      check($sformatf("v%0d_valid", k), ev_if.ev_valid, tbl[k].exp_valid);
      if (tbl[k].exp_valid) begin
        check($sformatf("v%0d_idx", k), ev_if.ev_idx, tbl[k].exp_idx);
        check($sformatf("v%0d_code", k), ev_if.ev_code, tbl[k].exp_code);
      end
      check($sformatf("v%0d_safety", k), safety_err, tbl[k].exp_safety);
      check($sformatf("v%0d_drop", k), ev_drop, tbl[k].exp_drop);
    end
    enable = 1'b1;
    clear  = 1'b0;

    // Starvation of philosopher 2: exactly one event after 100 hungry cycles.
    clear = 1'b1; st = 16'h0000; step(); clear = 1'b0;
    hits = 0; hit_k = 0; hit_idx = 3'd0; hit_code = 2'd0;
    for (int k = 1; k <= 110; k++) begin
      st = 16'h0030;
      step();
      if (ev_if.ev_valid) begin
        hits++;
        hit_k    = k;
        hit_idx  = ev_if.ev_idx;
        hit_code = ev_if.ev_code;
      end
      if (k == 100) begin
        check("starve_hmax100", hungry_max, 8'd100);
        check("starve_flag100", starve, 8'h04);
      end
    end
    check("starve_hits", hits, 1);
    check("starve_cycle", hit_k, 100);
    check("starve_idx", hit_idx, 3'd2);
    check("starve_code", hit_code, 2'd1);
    check("starve_flag", starve, 8'h04);
    check("starve_hmax110", hungry_max, 8'd110);
    st = 16'h0020; step();
    check("starve_eat_code", ev_if.ev_code, 2'd0);
    st = 16'h0000; step();

    // Overflow: six eat starts with the consumer stalled.
    clear = 1'b1; step(); clear = 1'b0;
    ev_if.ev_ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      eat_cycle(p);
      if (p == 3) check("ovf_drop_full", ev_drop, 8'd0);
    end
    check("ovf_valid", ev_if.ev_valid, 1'b1);
    check("ovf_head_idx", ev_if.ev_idx, 3'd0);
    check("ovf_head_code", ev_if.ev_code, 2'd0);
    check("ovf_drop", ev_drop, 8'd2);
    // Push into a full queue while popping the head.
    st = 16'h3000; step();
    st = 16'h2000; ev_if.ev_ready = 1'b1; step();
    st = 16'h0000; ev_if.ev_ready = 1'b0; step();
    check("pushpop_drop", ev_drop, 8'd2);
    exp_q[0] = 3'd1; exp_q[1] = 3'd2; exp_q[2] = 3'd3; exp_q[3] = 3'd6;
    ev_if.ev_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d_valid", k), ev_if.ev_valid, 1'b1);
      check($sformatf("drain%0d_idx", k), ev_if.ev_idx, exp_q[k]);
      step();
    end
    check("drain_empty", ev_if.ev_valid, 1'b0);

    // Asynchronous reset with three events queued.
    clear = 1'b1; step(); clear = 1'b0;
    ev_if.ev_ready = 1'b0;
    for (int p = 0; p < 3; p++) eat_cycle(p);
    check("prerst_valid", ev_if.ev_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", ev_if.ev_valid, 1'b0);
    check("arst_idx", ev_if.ev_idx, 3'd0);
    check("arst_code", ev_if.ev_code, 2'd0);
    check("arst_hmax", hungry_max, 8'd0);
    st = 16'h0080;
    #2 reset_n = 1'b1;
    step();
    check("postrst_first", ev_if.ev_valid, 1'b0);
    ev_if.ev_ready = 1'b1;
    step();
    check("postrst_second", ev_if.ev_valid, 1'b0);
    st = 16'h0000; step();
    check("postrst_third", ev_if.ev_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/philo_monitor.md
PHILO_MONITOR -- requirements
Module: philo_monitor

Interface
REQ-001 Parameter N, default 8: number of philosophers in the ring; minimum 3.
REQ-002 Parameter CNT_W, default 8: width of the wait, drop and max counters.
REQ-003 Parameter STARVE_LIMIT, default 100: hungry-cycle count that raises starvation; 1 to 2^CNT_W-1.
REQ-004 Parameter FIFO_DEPTH, default 4: depth of the event queue; power of two.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 st  in  2N  philosopher states; philosopher i occupies bits [2i+1:2i].
REQ-008 enable  in  1  high enables counting and event generation.
REQ-009 clear  in  1  synchronous clear of sticky flags, counters and queue.
REQ-010 ev_valid  out  1  event queue head is valid.
REQ-011 ev_ready  in  1  consumer accepts the head when high with ev_valid.
REQ-012 ev_idx  out  clog2(N)  philosopher index of the head event.
REQ-013 ev_code  out  2  event type: 0 EAT_START, 1 STARVE, 2 SAFETY, 3 ILLEGAL.
REQ-014 safety_err  out  1  sticky: two ring neighbours were seen eating together.
REQ-015 starve  out  N  sticky per-philosopher starvation flags.
REQ-016 ev_drop  out  CNT_W  saturating count of lost events.
REQ-017 hungry_max  out  CNT_W  largest wait count reached since reset or clear.

Function
REQ-018 State encoding is fixed: 0 THINK, 1 PASS, 2 EAT, 3 HUNGRY.
REQ-019 The ring neighbour of philosopher i is philosopher (i+1) mod N.
REQ-020 The block registers st into prev every cycle, including when enable is low.
REQ-021 A prev_valid bit is cleared by reset and by clear, and is set after the first sampled cycle.
REQ-022 Transition checks use st against prev and run only while prev_valid is set.
REQ-023 Legal transitions are 0->0/1/3, 1->1/0, 2->2/0 and 3->3/2; any other transition is ILLEGAL.
REQ-024 SAFETY is detected for i when st[i]==EAT and st[(i+1) mod N]==EAT.
REQ-025 EAT_START is detected when prev[i]==HUNGRY and st[i]==EAT.
REQ-026 Wait counter i increments each enabled cycle while st[i]==HUNGRY, saturates at all-ones, and clears to 0 on any cycle where st[i]!=HUNGRY.
REQ-027 STARVE is detected on the cycle that wait counter i becomes equal to STARVE_LIMIT, so it fires once per hungry episode.
REQ-028 STARVE detection also sets starve[i].
REQ-029 Any SAFETY detection sets safety_err.
REQ-030 hungry_max is updated to the maximum of its current value and all wait counters after each update.
REQ-031 At most one event is enqueued per cycle, chosen by priority SAFETY > ILLEGAL > STARVE > EAT_START, then by lowest index.
REQ-032 Each unselected detection increments ev_drop; ev_drop saturates.
REQ-033 A selected event that finds the queue full is dropped and increments ev_drop.
REQ-034 A pop and a push in the same cycle both succeed when the queue is full.
REQ-035 An event is visible on ev_valid/ev_idx/ev_code one cycle after the triggering st value is sampled.
REQ-036 ev_idx and ev_code hold stable while ev_valid is high and ev_ready is low.
REQ-037 With enable low, no detections occur, wait counters hold, and the queue still drains.
REQ-038 clear flushes the queue, zeroes all counters, clears all sticky flags and clears prev_valid; clear overrides a same-cycle detection.

Reset
REQ-039 reset_n low asynchronously forces ev_valid=0, ev_idx=0, ev_code=0, safety_err=0, starve=0, ev_drop=0, hungry_max=0, all wait counters=0, prev=0 and prev_valid=0.
REQ-040 Reset asserted mid-operation discards queued events without further handshakes.

Structure
REQ-041 Package philo_pkg holds the state encodings, the event codes and the legal-transition function.
REQ-042 Sub-module philo_watch is instantiated once per philosopher; it implements the wait counter, the transition check and the per-index detections.
REQ-043 The top level holds the priority select, the queue, ev_drop and hungry_max.

Verification
REQ-044 Philosopher 2 goes 0->3, then stays 3 for 100 cycles (N=8, STARVE_LIMIT=100) -> exactly one STARVE idx 2; starve=8'h04; hungry_max=100.
REQ-045 Philosophers 4 and 5 both in state 2 -> SAFETY idx 4 one cycle later; safety_err=1 and stays set until clear.
REQ-046 Philosopher 1 goes 0->2 directly while philosopher 6 goes 3->2 in the same cycle -> ILLEGAL idx 1 enqueued; ev_drop=1.
REQ-047 ev_ready held low while 6 EAT_START events occur on separate cycles -> 4 queued in order; ev_drop=2; the queued events then drain in order once ev_ready=1.
REQ-048 reset_n pulsed low with 3 events queued -> ev_valid=0 immediately; the first post-reset sample raises no ILLEGAL.
REQ-049 clear asserted in the same cycle as a SAFETY condition -> safety_err=0, queue empty, ev_drop=0.
